// File: rtl/caddr_pkg.sv
// caddr_pkg: shared state, opcode, spy address and mode bit definitions for the CADR core
package caddr_pkg;
   typedef enum logic [1:0] {HALTED = 2'd0, RUN = 2'd1, STEP = 2'd2} state_t;
   localparam logic [1:0] OP_NEXT = 2'd0;
   localparam logic [1:0] OP_JUMP = 2'd1;
   localparam logic [1:0] OP_HALT = 2'd2;
   localparam logic [1:0] OP_INTJ = 2'd3;
   localparam logic [3:0] SPY_IR0 = 4'd0;
   localparam logic [3:0] SPY_IR1 = 4'd1;
   localparam logic [3:0] SPY_IR2 = 4'd2;
   localparam logic [3:0] SPY_PC = 4'd3;
   localparam logic [3:0] SPY_OPC = 4'd4;
   localparam logic [3:0] SPY_STATUS = 4'd5;
   localparam logic [3:0] SPY_MODE = 4'd6;
   localparam logic [3:0] SPY_CNT = 4'd7;
   localparam int MODE_HALT = 0;
   localparam int MODE_STEP = 1;
   localparam int MODE_IMEM_WR = 2;
endpackage

// File: rtl/caddr_spy.sv
// caddr_spy: spy bus read mux, tristate driver and write strobe decode
module caddr_spy
   import caddr_pkg::*;
(
   inout wire [15:0] spy,
   input logic dbread_n,
   input logic dbwrite_n,
   input logic [3:0] eadr,
   input logic [47:0] ir,
   input logic [15:0] pc,
   input logic [15:0] opc,
   input logic [15:0] status,
   input logic [15:0] mode,
   input logic [15:0] counter,
   output logic [2:0] wr_ir,
   output logic wr_pc,
   output logic wr_mode,
   output logic wr_cnt,
   output logic [15:0] wr_data
);
   logic [15:0] rd_map [8];
   logic [15:0] rd;
   logic we;
   always_comb begin
      rd_map = '{ir[15:0], ir[31:16], ir[47:32], pc, opc, status, mode, counter};
      rd = eadr[3] ? 16'h0000 : rd_map[eadr[2:0]];
      we = !dbwrite_n;
      wr_ir = {we && eadr == SPY_IR2, we && eadr == SPY_IR1, we && eadr == SPY_IR0};
      wr_pc = we && eadr == SPY_PC;
      wr_mode = we && eadr == SPY_MODE;
      wr_cnt = we && eadr == SPY_CNT;
   end
   assign spy = dbread_n ? 16'bz : rd;
   assign wr_data = spy;
endmodule

// File: rtl/caddr_core.sv
// caddr_core: reduced CADR microsequencer with writable I-mem, boot/run FSM and spy debug bus
module caddr_core
   import caddr_pkg::*;
#(
   parameter int PC_W = 14,
   parameter int IMEM_AW = 8,
   parameter int BOOT_PC = 0
) (
   input logic clk,
   input logic reset,
   input logic int_req,
   input logic boot1_n,
   input logic boot2_n,
   inout wire [15:0] spy,
   input logic dbread_n,
   input logic dbwrite_n,
   input logic [3:0] eadr
);
   state_t state;
   logic [PC_W-1:0] pc, opc, pc_next, target;
   logic [47:0] ir, w;
   logic [15:0] mode, counter, status, wr_data;
   logic [2:0] wr_ir;
   logic [1:0] op;
   logic int_pending, boot_seen, boot, exec, take_int, wr_pc, wr_mode, wr_cnt;
   logic [47:0] imem [2**IMEM_AW];

   assign boot = !boot1_n && !boot2_n;
   assign w = imem[pc[IMEM_AW-1:0]];
   assign op = w[15:14];
   assign target = PC_W'(w[13:0]);
   assign exec = !boot && (state == STEP || (state == RUN && !mode[MODE_HALT]));
   assign take_int = exec && op == OP_INTJ && int_pending;
   assign pc_next = (op == OP_JUMP || take_int) ? target : pc + PC_W'(1);
   assign status = {11'b0, state, int_pending, state == HALTED, boot_seen};

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= HALTED;
         pc <= '0;
         opc <= '0;
         ir <= '0;
         mode <= '0;
         int_pending <= 1'b0;
         counter <= '0;
         boot_seen <= 1'b0;
      end else begin
         int_pending <= int_req || (int_pending && !take_int);
         if (boot) begin
            pc <= PC_W'(BOOT_PC);
            mode[MODE_HALT] <= 1'b0;
            boot_seen <= 1'b1;
            state <= RUN;
         end else begin
            if (exec) begin
               ir <= w;
               opc <= pc;
               pc <= pc_next;
               counter <= counter + 16'd1;
               state <= (state == STEP || op == OP_HALT) ? HALTED : RUN;
            end else if (state == RUN) begin
               state <= HALTED;
            end
            // spy writes land after execution so they override the same register
            if (wr_ir[0]) ir[15:0] <= wr_data;
            if (wr_ir[1]) ir[31:16] <= wr_data;
            if (wr_ir[2]) ir[47:32] <= wr_data;
            if (wr_pc) pc <= wr_data[PC_W-1:0];
            if (wr_cnt) counter <= '0;
            if (wr_mode) begin
               mode <= {wr_data[15:3], 2'b00, wr_data[MODE_HALT]};
               if (wr_data[MODE_STEP] && state == HALTED) state <= STEP;
            end
         end
      end
   end

   always_ff @(posedge clk)
      if (!reset && !boot && wr_mode && wr_data[MODE_IMEM_WR]) imem[pc[IMEM_AW-1:0]] <= ir;

   caddr_spy u_spy (
      .spy(spy),
      .dbread_n(dbread_n),
      .dbwrite_n(dbwrite_n),
      .eadr(eadr),
      .ir(ir),
      .pc(16'(pc)),
      .opc(16'(opc)),
      .status(status),
      .mode(mode),
      .counter(counter),
      .wr_ir(wr_ir),
      .wr_pc(wr_pc),
      .wr_mode(wr_mode),
      .wr_cnt(wr_cnt),
      .wr_data(wr_data)
   );
endmodule

// File: tb/tb_caddr_core.sv
// tb_caddr_core: directed spy-bus bench for caddr_core
module tb_caddr_core;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic int_req = 1'b0;
   logic boot1_n = 1'b0;
   logic boot2_n = 1'b0;
   logic dbread_n = 1'b1;
   logic dbwrite_n = 1'b1;
   logic [3:0] eadr = 4'd0;
   logic [15:0] spy_drv = 16'h0000;
   logic spy_oe = 1'b0;
   wire [15:0] spy;
   int checks = 0;
   int failures = 0;

   assign spy = spy_oe ? spy_drv : 16'bz;
   always #5 clk = ~clk;

   caddr_core dut (
      .clk(clk),
      .reset(reset),
      .int_req(int_req),
      .boot1_n(boot1_n),
      .boot2_n(boot2_n),
      .spy(spy),
      .dbread_n(dbread_n),
      .dbwrite_n(dbwrite_n),
      .eadr(eadr)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd_chk(input string tag, input logic [3:0] a, input logic [15:0] exp);
      eadr = a;
      dbread_n = 1'b0;
      #1;
      check(tag, spy, exp);
      dbread_n = 1'b1;
   endtask

   task automatic spy_wr(input logic [3:0] a, input logic [15:0] d);
      @(negedge clk);
      eadr = a;
      spy_drv = d;
      spy_oe = 1'b1;
      dbwrite_n = 1'b0;
      @(negedge clk);
      dbwrite_n = 1'b1;
      spy_oe = 1'b0;
   endtask

   task automatic load(input logic [15:0] addr, input logic [15:0] lo);
      spy_wr(4'd3, addr);
      spy_wr(4'd0, lo);
      spy_wr(4'd1, 16'h0000);
      spy_wr(4'd2, 16'h0000);
      spy_wr(4'd6, 16'h0004);
   endtask

   task automatic do_boot();
      @(negedge clk);
      boot1_n = 1'b0;
      boot2_n = 1'b0;
      @(negedge clk);
      boot1_n = 1'b1;
      boot2_n = 1'b1;
   endtask

   initial begin
      repeat (12) @(negedge clk);
      rd_chk("reset_status", 4'd5, 16'h0002);
      rd_chk("reset_pc", 4'd3, 16'h0000);
      rd_chk("reset_cnt", 4'd7, 16'h0000);
      @(negedge clk);
      reset = 1'b0;
      boot1_n = 1'b1;
      boot2_n = 1'b1;
      // single boot key does nothing
      @(negedge clk);
      boot1_n = 1'b0;
      @(negedge clk);
      boot1_n = 1'b1;
      rd_chk("one_key_status", 4'd5, 16'h0002);
      // program A: next, jump 0, halt
      load(16'd0, 16'h0000);
      load(16'd1, 16'h4000);
      load(16'd2, 16'h8000);
      rd_chk("ir_lo_loaded", 4'd0, 16'h8000);
      rd_chk("mode_selfclr", 4'd6, 16'h0000);
      do_boot();
      rd_chk("boot_status", 4'd5, 16'h0009);
      rd_chk("boot_pc", 4'd3, 16'h0000);
      @(negedge clk);
      rd_chk("loop_pc1", 4'd3, 16'h0001);
      rd_chk("loop_cnt1", 4'd7, 16'h0001);
      @(negedge clk);
      rd_chk("loop_pc2", 4'd3, 16'h0000);
      rd_chk("loop_cnt2", 4'd7, 16'h0002);
      rd_chk("loop_opc2", 4'd4, 16'h0001);
      @(negedge clk);
      rd_chk("loop_pc3", 4'd3, 16'h0001);
      rd_chk("loop_ir3", 4'd0, 16'h0000);
      spy_wr(4'd6, 16'h0001);
      @(negedge clk);
      rd_chk("halt_status", 4'd5, 16'h0003);
      rd_chk("halt_mode", 4'd6, 16'h0001);
      // program B: five sequential words then halt at 5
      load(16'd1, 16'h0000);
      load(16'd2, 16'h0000);
      load(16'd3, 16'h0000);
      load(16'd4, 16'h0000);
      load(16'd5, 16'h8000);
      spy_wr(4'd7, 16'h0000);
      do_boot();
      repeat (10) @(negedge clk);
      rd_chk("prog_b_pc", 4'd3, 16'h0006);
      rd_chk("prog_b_opc", 4'd4, 16'h0005);
      rd_chk("prog_b_cnt", 4'd7, 16'h0006);
      rd_chk("prog_b_status", 4'd5, 16'h0003);
      // single stepping
      load(16'd6, 16'h0000);
      load(16'd7, 16'h0000);
      load(16'd8, 16'h0000);
      spy_wr(4'd3, 16'd6);
      for (int i = 0; i < 3; i++) begin
         spy_wr(4'd6, 16'h0002);
         @(negedge clk);
         rd_chk($sformatf("step%0d_pc", i), 4'd3, 16'(7 + i));
         rd_chk($sformatf("step%0d_status", i), 4'd5, 16'h0003);
      end
      rd_chk("step_cnt", 4'd7, 16'h0009);
      rd_chk("step_mode", 4'd6, 16'h0000);
      // interrupt jump
      load(16'd0, 16'hC010);
      load(16'd1, 16'h4000);
      load(16'h10, 16'h8000);
      do_boot();
      @(negedge clk);
      rd_chk("intj_noint_pc", 4'd3, 16'h0001);
      @(negedge clk);
      int_req = 1'b1;
      @(negedge clk);
      int_req = 1'b0;
      rd_chk("int_pending_set", 4'd5, 16'h000D);
      rd_chk("int_pc4", 4'd3, 16'h0001);
      @(negedge clk);
      @(negedge clk);
      rd_chk("intj_taken_pc", 4'd3, 16'h0010);
      rd_chk("intj_cleared", 4'd5, 16'h0009);
      @(negedge clk);
      rd_chk("intj_halt_pc", 4'd3, 16'h0011);
      rd_chk("intj_halt_status", 4'd5, 16'h0003);
      rd_chk("intj_cnt", 4'd7, 16'h000F);
      // bus release, unmapped read, ignored write
      @(negedge clk);
      eadr = 4'd3;
      spy_drv = 16'hA5A5;
      spy_oe = 1'b1;
      #1;
      check("spy_released", spy, 16'hA5A5);
      spy_oe = 1'b0;
      rd_chk("unmapped_read", 4'd9, 16'h0000);
      spy_wr(4'd12, 16'hFFFF);
      rd_chk("w12_pc", 4'd3, 16'h0011);
      rd_chk("w12_ir", 4'd0, 16'h8000);
      rd_chk("w12_mode", 4'd6, 16'h0000);
      @(negedge clk);
      rd_chk("w12_cnt", 4'd7, 16'h000F);
      rd_chk("w12_status", 4'd5, 16'h0003);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/caddr_core.md
Name: caddr_core

Overview:
Reduced CADR-style microcode processor core: a microsequencer, a small writable instruction memory (I-mem), a boot/run control FSM and a 16-bit spy debug bus. The spy bus gives an external console read/write access to internal registers. Top-level CPU block of the CADR model, instantiated directly by the system/bench.

Parameters:
PC_W, 14, micro-PC width
IMEM_AW, 8, I-mem address bits (depth 2^IMEM_AW, indexed by PC[IMEM_AW-1:0])
BOOT_PC, 0, PC loaded on boot

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset (one clock domain only)
int  in  1  interrupt request, sampled every clk
boot1_n  in  1  boot key 1, active low
boot2_n  in  1  boot key 2, active low
spy  inout  16  bidirectional debug data bus
dbread_n  in  1  spy read strobe, active low
dbwrite_n  in  1  spy write strobe, active low
eadr  in  4  spy register select

Behaviour:
- State register: HALTED, RUN, STEP. Reset -> HALTED; PC=0, OPC=0, IR=0, mode=0, int_pending=0, counter=0, boot_seen=0. I-mem contents are not reset.
- Boot: boot1_n=0 AND boot2_n=0 sampled with reset=0 -> next cycle PC=BOOT_PC, mode.halt=0, boot_seen=1, state=RUN. While reset=1, boot keys are ignored. A single boot key low does nothing.
- int_pending: sticky; set on any cycle int=1; cleared by a taken op 11 or by reset. Set wins over clear in the same cycle.
- Instruction word w = imem[PC], 48 bits, combinational read. op = w[15:14], target = w[13:0].
- One instruction per cycle in RUN/STEP: IR<=w, OPC<=PC, counter+=1 (16-bit, wraps), PC<=next:
  op 00: PC+1 (mod 2^PC_W)
  op 01: target
  op 10: PC+1, state->HALTED
  op 11: if int_pending, target and clear int_pending; else PC+1
- STEP executes exactly one instruction, then state->HALTED.
- mode.halt=1 in RUN -> HALTED at the next edge; no instruction executes that cycle.
- Spy read: dbread_n=0 -> spy driven with the selected value, otherwise high-Z. Zero latency.
  Read map: 0 IR[15:0], 1 IR[31:16], 2 IR[47:32], 3 PC zero-extended, 4 OPC, 5 status {11'b0, state[1:0], int_pending, halted, boot_seen}, 6 mode, 7 counter; 8-15 read 0.
- Spy write: dbwrite_n=0 captures spy at the edge.
  0/1/2: IR slice
  3: PC
  6: mode. bit0 halt (level). bit1 step, self-clearing: if HALTED, state->STEP. bit2 imem write, self-clearing: imem[PC]<=IR.
  7: counter<=0
  Others ignored.
- Priority in one cycle: reset > boot > spy write > execution. A spy write to PC or IR overrides the execution update of that register.
- dbread_n and dbwrite_n both low: the write occurs and the read still drives the pre-edge value.

Decomposition:
- Shared package caddr_pkg: state enum; op codes (OP_NEXT, OP_JUMP, OP_HALT, OP_INTJ); spy address constants 0-7; mode bit indices.
- One sub-module, caddr_spy: read mux, tristate driver and write decode.
- Sequencer, FSM and I-mem stay in caddr_core.

Test Plan:
- Reset for 13 cycles, boot keys low during reset -> state HALTED, PC=0, status=0x0002. Release reset, pulse both boot keys 1 cycle -> RUN, PC=BOOT_PC, boot_seen=1.
- Load I-mem through spy: PC=0, IR={0,0,0x0000} imem write; PC=1, IR low=0x4000 (jump 0); PC=2, IR low=0x8000 (halt). Boot -> PC sequence 0,1,0,1,...; counter increments by 1 per cycle.
- Place halt at address 5 with op 00 at 0-4. Boot -> HALTED after 6 instructions; PC=6, OPC=5, counter=6.
- int pulsed 1 cycle while looping on word 0x C010 at address 0 (op 11, target 0x0010) -> next PC=0x10, int_pending clears; with no int, PC=1.
- Halted core, write mode=0x0002 three times -> three instructions execute, PC advances by 3, state HALTED after each step.
- dbread_n=1 -> spy high-Z. eadr=9 read -> 0x0000. Write to eadr 12 -> no register changes.
